// File: rtl/uart_crc_pkg.sv
// Shared CRC-8 UART link definitions: polynomial, frame size, transmitter states.
// Used by both the transmitter and the receiver-side checker.
package uart_crc_pkg;

   localparam logic [7:0] CRC8_POLY  = 8'h07;
   localparam logic [7:0] CRC8_INIT  = 8'h00;
   localparam int         FRAME_BITS = 18;

   typedef enum logic [2:0] {
      IDLE,
      CRC_CALC,
      START,
      DATA,
      CRC,
      STOP
   } tx_state_t;

   // One MSB-first step of the unreflected CRC-8 shift register
   function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                            input logic       din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 register, one input bit per enabled clock.
// Shared with the receiver for frame checking.
module crc8_serial
   import uart_crc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       din,
   output logic [7:0] crc
);

   logic [7:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clear)
         crc_d = CRC8_INIT;
      else if (enable)
         crc_d = crc8_step(crc_q, din);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         crc_q <= CRC8_INIT;
      else
         crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/uart_crc_transmitter.sv
// UART transmitter sending start, data, CRC-8 and stop bits at 16x tick timing.
// UART_CRC_ERR_INJECT_EN adds err_inject to flip bit 0 of the sent CRC.
module uart_crc_transmitter
   import uart_crc_pkg::*;
#(
   parameter int BAUD_RATE         = 9600,
   parameter int CLK_FREQ          = 50000000,
   parameter int OVERSAMPLING_RATE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] data_in,
`ifdef UART_CRC_ERR_INJECT_EN
   input  logic       err_inject,
`endif
   output logic       tx_out,
   output logic       tx_busy,
   output logic       tx_done,
   output logic [7:0] crc_out
);

   localparam int TICK_MAX = (CLK_FREQ / (BAUD_RATE * OVERSAMPLING_RATE)) - 1;
   localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
   localparam int SW = $clog2(OVERSAMPLING_RATE);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLING_RATE - 1);

   tx_state_t     state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    crc_out_q, crc_out_d;
   logic          tx_out_q, tx_out_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [SW-1:0] samp_q, samp_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    crc_tx;
   logic [7:0]    crc_val;
   logic          crc_clr, crc_en, crc_din;
   logic          tick_end, bit_end;

`ifdef UART_CRC_ERR_INJECT_EN
   logic inj_q, inj_d;
   assign crc_tx = crc_out_q ^ {7'b0, inj_q};
`else
   assign crc_tx = crc_out_q;
`endif

   crc8_serial u_crc (
      .clk    (clk),
      .reset  (reset),
      .clear  (crc_clr),
      .enable (crc_en),
      .din    (crc_din),
      .crc    (crc_val)
   );

   assign tick_end = (tick_q == TICK_LAST);
   assign bit_end  = tick_end && (samp_q == SAMP_LAST);

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      crc_out_d = crc_out_q;
      tick_d    = tick_q;
      samp_d    = samp_q;
      bit_d     = bit_q;
      crc_clr   = 1'b0;
      crc_en    = 1'b0;
      crc_din   = data_q[3'd7 - bit_q[2:0]];
      tx_done   = 1'b0;
`ifdef UART_CRC_ERR_INJECT_EN
      inj_d     = inj_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (tx_start) begin
               data_d  = data_in;
               crc_clr = 1'b1;
               bit_d   = 4'd0;
               state_d = CRC_CALC;
`ifdef UART_CRC_ERR_INJECT_EN
               inj_d   = err_inject;
`endif
            end
         end
         CRC_CALC: begin
            // 8 shift clocks, then one clock to load the finished CRC
            if (bit_q == 4'd8) begin
               crc_out_d = crc_val;
               tick_d    = '0;
               samp_d    = '0;
               bit_d     = 4'd0;
               state_d   = START;
            end else begin
               crc_en = 1'b1;
               bit_d  = bit_q + 4'd1;
            end
         end
         START, DATA, CRC, STOP: begin
            tick_d = tick_end ? '0 : tick_q + 1'b1;
            if (tick_end)
               samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
            if (bit_end) begin
               unique case (state_q)
                  START: begin
                     state_d = DATA;
                     bit_d   = 4'd0;
                  end
                  DATA: begin
                     bit_d = (bit_q == 4'd7) ? 4'd0 : bit_q + 4'd1;
                     if (bit_q == 4'd7)
                        state_d = CRC;
                  end
                  CRC: begin
                     bit_d = (bit_q == 4'd7) ? 4'd0 : bit_q + 4'd1;
                     if (bit_q == 4'd7)
                        state_d = STOP;
                  end
                  STOP: begin
                     tx_done = 1'b1;
                     state_d = IDLE;
                  end
                  default: state_d = state_q;
               endcase
            end
         end
      endcase

      // Line level follows the state being entered so tx_out is a clean flop
      case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = data_q[bit_d[2:0]];
         CRC:     tx_out_d = crc_tx[bit_d[2:0]];
         default: tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         data_q    <= 8'h00;
         crc_out_q <= 8'h00;
         tx_out_q  <= 1'b1;
         tick_q    <= '0;
         samp_q    <= '0;
         bit_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         crc_out_q <= crc_out_d;
         tx_out_q  <= tx_out_d;
         tick_q    <= tick_d;
         samp_q    <= samp_d;
         bit_q     <= bit_d;
      end
   end

`ifdef UART_CRC_ERR_INJECT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         inj_q <= 1'b0;
      else
         inj_q <= inj_d;
   end
`endif

   assign tx_out  = tx_out_q;
   assign tx_busy = (state_q != IDLE);
   assign crc_out = crc_out_q;

endmodule

// File: tb/tb_uart_crc_transmitter.sv
// Scoreboard bench: accepts are predicted from the handshake rules, the line
// is decoded at bit centres and compared with a polynomial-division CRC model.
module tb_uart_crc_transmitter;
   import uart_crc_pkg::*;

   localparam int BAUD = 9600;
   localparam int OS   = 16;
   localparam int CLKF = BAUD * OS * 3;
   localparam int P    = OS * (CLKF / (BAUD * OS));
   localparam int DONE_EDGE = 9 + FRAME_BITS * P;

   typedef struct {
      logic [7:0] d;
      logic [7:0] c;
      logic       inj;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] data_in;
   logic       err_inject;
   logic       tx_out, tx_busy, tx_done;
   logic [7:0] crc_out;

   uart_crc_transmitter #(
      .BAUD_RATE         (BAUD),
      .CLK_FREQ          (CLKF),
      .OVERSAMPLING_RATE (OS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_start   (tx_start),
      .data_in    (data_in),
`ifdef UART_CRC_ERR_INJECT_EN
      .err_inject (err_inject),
`endif
      .tx_out     (tx_out),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .crc_out    (crc_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // CRC as remainder of d * x^8 divided by x^8+x^2+x+1
   function automatic logic [7:0] ref_crc(input logic [7:0] d);
      logic [15:0] v;
      v = {d, 8'h00};
      for (int i = 15; i >= 8; i--)
         if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
      return v[7:0];
   endfunction

   exp_t        frame_q[$];
   int          total = 0;
   int          bad = 0;
   logic        prev_rst = 1'b0;
   logic        m_have = 1'b0;
   int          m_acc = 0;
   logic [7:0]  m_crc = 8'h00;
   int          n_acc = 0;
   logic        rx_busy = 1'b0;
   int          rx_n = 0;
   int          rx_fall = 0;
   int          prev_fall = 0;
   int          frames_seen = 0;
   int          gap_frame = -1;
   logic [17:0] rx_bits;
   logic        fin_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      logic eb, ed, inj_now;
      if (reset) begin
         if (!prev_rst) begin
            chk("reset_tx_out", 32'(tx_out), 32'd1);
            chk("reset_busy", 32'(tx_busy), 32'd0);
            chk("reset_done", 32'(tx_done), 32'd0);
            chk("reset_crc_out", 32'(crc_out), 32'd0);
         end
         m_have = 1'b0;
         rx_busy = 1'b0;
         frame_q.delete();
      end else begin
         eb = m_have && cyc >= m_acc && cyc < m_acc + DONE_EDGE;
         ed = m_have && cyc == m_acc + DONE_EDGE - 1;
         chk("busy", 32'(tx_busy), 32'(eb));
         chk("done", 32'(tx_done), 32'(ed));
         if (ed) chk("crc_out_at_done", 32'(crc_out), 32'(m_crc));

         if (!rx_busy && tx_out == 1'b0) begin
            rx_busy = 1'b1;
            rx_n = 0;
            rx_fall = cyc;
            if (frame_q.size() != 0)
               chk("crc_out_at_start", 32'(crc_out), 32'(frame_q[0].c));
         end
         if (rx_busy) begin
            if (rx_n % P == P / 2) rx_bits[rx_n / P] = tx_out;
            rx_n++;
            if (rx_n == FRAME_BITS * P) begin
               rx_busy = 1'b0;
               frames_seen++;
               chk("frame_expected", 32'(frame_q.size() != 0), 32'd1);
               if (frame_q.size() != 0) begin
                  e = frame_q.pop_front();
                  chk("start_bit", 32'(rx_bits[0]), 32'd0);
                  chk("data_field", 32'(rx_bits[8:1]), 32'(e.d));
                  chk("crc_field", 32'(rx_bits[16:9]),
                      32'(e.c ^ {7'b0, e.inj}));
                  chk("stop_bit", 32'(rx_bits[17]), 32'd1);
                  chk("start_latency", 32'(rx_fall - e.acc), 32'd9);
               end
               if (frames_seen == gap_frame)
                  chk("b2b_gap", 32'(rx_fall - prev_fall),
                      32'(FRAME_BITS * P + 10));
               prev_fall = rx_fall;
            end
         end

         // Next edge accepts only once the previous frame's done edge is past
         if (tx_start && !(m_have && cyc + 1 <= m_acc + DONE_EDGE)) begin
`ifdef UART_CRC_ERR_INJECT_EN
            inj_now = err_inject;
`else
            inj_now = 1'b0;
`endif
            e.d = data_in;
            e.c = ref_crc(data_in);
            e.inj = inj_now;
            e.acc = cyc + 1;
            frame_q.push_back(e);
            m_have = 1'b1;
            m_acc = cyc + 1;
            m_crc = e.c;
            n_acc++;
         end

         if (fin_req) begin
            chk("queue_drained", 32'(frame_q.size()), 32'd0);
            chk("decoder_idle", 32'(rx_busy), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
      prev_rst = reset;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((tx_busy || rx_busy) && n < 3 * DONE_EDGE) begin
         step();
         n++;
      end
      if (n >= 3 * DONE_EDGE) begin
         $display("FAIL wait_idle: busy=%0b after %0d cycles, want 0", tx_busy, n);
         $fatal(1);
      end
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc < target && n < 3 * DONE_EDGE) begin
         step();
         n++;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic inj);
      wait_idle();
      tx_start = 1'b1;
      data_in = d;
      err_inject = inj;
      step();
      tx_start = 1'b0;
      data_in = 8'($urandom);
      err_inject = 1'($urandom);
   endtask

   initial begin : stim
      int base, n;
      reset = 1'b1;
      tx_start = 1'b0;
      data_in = 8'h00;
      err_inject = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();

      send(8'h31, 1'b0);
      send(8'h31, 1'b1);

      wait_idle();
      gap_frame = frames_seen + 2;
      base = n_acc;
      tx_start = 1'b1;
      data_in = 8'h00;
      n = 0;
      while (n_acc < base + 1 && n < 100) begin step(); n++; end
      step();
      data_in = 8'h01;
      n = 0;
      while (n_acc < base + 2 && n < 2 * DONE_EDGE) begin step(); n++; end
      step();
      tx_start = 1'b0;

      send(8'h80, 1'b0);
      wait_cyc(m_acc + 9 + 3 * P);
      tx_start = 1'b1;
      data_in = 8'hFF;
      step();
      tx_start = 1'b0;

      send(8'h5A, 1'b0);
      wait_cyc(m_acc + 9 + 12 * P);
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      step();
      send(8'h31, 1'b0);
      send(8'hFF, 1'b0);

      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 5)) step();
         send(8'($urandom), 1'($urandom));
      end

      wait_idle();
      repeat (4) step();
      fin_req = 1'b1;
      repeat (20) step();
      $display("FAIL finish: monitor did not end the run");
      $fatal(1);
   end

endmodule
